// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM port among NUM_REQ requesters, one transaction in flight.
// Define RAM_ARB_TIMEOUT_EN to answer a read with an error response after TIMEOUT cycles without RAM read-valid.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic                            rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id_o,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic                            rsp_err_o,
  output logic                            ram_read_o,
  output logic [ADDR_WIDTH-1:0]           ram_read_index_o,
  output logic                            ram_write_o,
  output logic [ADDR_WIDTH-1:0]           ram_write_index_o,
  output logic [DATA_WIDTH-1:0]           ram_write_data_o,
  input  logic                            ram_read_valid_i,
  input  logic [DATA_WIDTH-1:0]           ram_read_value_i
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] rr_ptr, win, k, cap_id;
  logic hit, grant, tmo, done;
  int j;
  always_comb begin
    win = '0;
    hit = 1'b0;
    j = 0;
    k = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      k = IDW'(j >= NUM_REQ ? j - NUM_REQ : j);
      if (!hit && req_i[k]) begin
        hit = 1'b1;
        win = k;
      end
    end
  end
  assign grant = state == IDLE && hit;
  // grant is combinational, so it must also be masked while reset is held
  assign gnt_o = (rst && grant) ? NUM_REQ'(1) << win : '0;
  assign done  = state == WAIT && (ram_read_valid_i || tmo);
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (hit ? ISSUE : IDLE) :
               state == ISSUE ? (ram_write_o ? IDLE : WAIT) :
               done ? IDLE : WAIT;
  end
`ifdef RAM_ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  assign tmo = state == WAIT && !ram_read_valid_i && cnt == LIMIT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (state == WAIT && state_nx == WAIT) ? cnt + 8'd1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      cap_id            <= '0;
      ram_write_o       <= 1'b0;
      ram_read_o        <= 1'b0;
      ram_read_index_o  <= '0;
      ram_write_index_o <= '0;
      ram_write_data_o  <= '0;
      rsp_valid_o       <= 1'b0;
      rsp_err_o         <= 1'b0;
      rsp_id_o          <= '0;
      rsp_data_o        <= '0;
    end else begin
      state       <= state_nx;
      ram_write_o <= grant && we_i[win];
      ram_read_o  <= grant && !we_i[win];
      rsp_valid_o <= done;
      rsp_err_o   <= tmo;
      if (grant) begin
        rr_ptr            <= win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        cap_id            <= win;
        ram_read_index_o  <= addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_write_index_o <= addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_write_data_o  <= wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (done) begin
        rsp_id_o   <= cap_id;
        rsp_data_o <= ram_read_valid_i ? ram_read_value_i : '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized transactions checked against a transaction-level round-robin model.
module tb_ram_port_arbiter;
  localparam int DW = 32, AW = 5, N = 4, IW = 2, TO = 4;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_i = '0, we_i = '0, gnt_o;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic rsp_valid_o, rsp_err_o, ram_read_o, ram_write_o;
  logic [IW-1:0] rsp_id_o;
  logic [DW-1:0] rsp_data_o, ram_write_data_o;
  logic [AW-1:0] ram_read_index_o, ram_write_index_o;
  logic ram_read_valid_i = 1'b0;
  logic [DW-1:0] ram_read_value_i = '0;
  int checks = 0, errors = 0, rr = 0;
  logic [DW-1:0] last_data = '0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .ram_read_o(ram_read_o), .ram_read_index_o(ram_read_index_o),
    .ram_write_o(ram_write_o), .ram_write_index_o(ram_write_index_o),
    .ram_write_data_o(ram_write_data_o), .ram_read_valid_i(ram_read_valid_i),
    .ram_read_value_i(ram_read_value_i));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one request round starting in an idle cycle; lat = WAIT cycles before RAM valid
  task automatic txn(input logic [N-1:0] rq, input logic [N-1:0] wv, input int lat);
    int w, wait_n;
    bit tmo;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [DW-1:0] rv;
    rv = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = AW'($urandom);
      d[i] = $urandom;
      addr_i[i*AW +: AW] = a[i];
      wdata_i[i*DW +: DW] = d[i];
    end
    req_i = rq;
    we_i = wv;
    ram_read_valid_i = 1'($urandom);
    ram_read_value_i = $urandom;
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && rq[(rr + i) % N]) w = (rr + i) % N;
    @(negedge clk);
    check("gnt", DW'(gnt_o), DW'(1) << w);
    check("rsp_hold", rsp_data_o, last_data);
    check("rsp_idle", DW'(rsp_valid_o), 0);
    rr = (w + 1) % N;
    @(posedge clk); #1;
    req_i = '0;
    ram_read_valid_i = 1'($urandom);
    @(negedge clk);
    check("gnt_issue", DW'(gnt_o), 0);
    check("rsp_issue", DW'(rsp_valid_o), 0);
    check("wr_stb", DW'(ram_write_o), DW'(wv[w]));
    check("rd_stb", DW'(ram_read_o), DW'(!wv[w]));
    if (wv[w]) begin
      check("wr_idx", DW'(ram_write_index_o), DW'(a[w]));
      check("wr_data", ram_write_data_o, d[w]);
    end else
      check("rd_idx", DW'(ram_read_index_o), DW'(a[w]));
    @(posedge clk); #1;
    ram_read_valid_i = 1'b0;
    if (wv[w]) return;
    tmo = TEN && lat >= TO;
    wait_n = tmo ? TO - 1 : lat;
    for (int c = 0; c <= wait_n; c++) begin
      req_i = N'($urandom);
      ram_read_valid_i = (c == lat);
      rv = $urandom;
      ram_read_value_i = rv;
      @(negedge clk);
      check("rsp_wait", DW'(rsp_valid_o), 0);
      check("gnt_wait", DW'(gnt_o), 0);
      check("stb_wait", DW'({ram_read_o, ram_write_o}), 0);
      @(posedge clk); #1;
    end
    req_i = '0;
    ram_read_valid_i = 1'b0;
    last_data = tmo ? '0 : rv;
    @(negedge clk);
    check("rsp_valid", DW'(rsp_valid_o), 1);
    check("rsp_id", DW'(rsp_id_o), DW'(w));
    check("rsp_err", DW'(rsp_err_o), DW'(tmo));
    check("rsp_data", rsp_data_o, last_data);
    @(posedge clk); #1;
    check("rsp_pulse", DW'(rsp_valid_o), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, DW'(gnt_o), 0);
    check({tag, "_stb"}, DW'({ram_read_o, ram_write_o, rsp_valid_o, rsp_err_o}), 0);
    check({tag, "_idx"}, DW'({ram_read_index_o, ram_write_index_o, rsp_id_o}), 0);
    check({tag, "_wdata"}, ram_write_data_o, 0);
    check({tag, "_rdata"}, rsp_data_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(4'b0001, 4'b0001, 0);
    txn(4'b0100, 4'b0000, 0);
    txn(4'b0011, 4'b1111, 0);
    txn(4'b0011, 4'b1111, 0);
    for (int i = 0; i < 5; i++) txn(4'b1111, 4'b1111, 0);
    txn(4'b0001, 4'b0000, 6);
    txn(4'b0010, 4'b0000, 3);
    txn(4'b0100, 4'b0000, 2);
    // reset while waiting for read data: the read must be abandoned
    req_i = 4'b0010;
    we_i = 4'b0000;
    @(posedge clk); #1;
    req_i = '0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_zero("mid_reset");
    rr = 0;
    last_data = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    ram_read_valid_i = 1'b1;
    ram_read_value_i = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_valid", DW'({rsp_valid_o, ram_read_o, ram_write_o}), 0);
      @(posedge clk); #1;
    end
    ram_read_valid_i = 1'b0;
    txn(4'b1111, 4'b1111, 0);
    for (int i = 0; i < 80; i++)
      txn(N'($urandom_range(1, 15)), N'($urandom), $urandom_range(0, 6));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
